// File: rtl/fact_initiator_pkg.sv
// Shared types and constants for the factorial-accelerator bus initiator:
// FSM states, register word offsets and STATUS bit positions.
package fact_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_N   = 3'd1,
    WR_GO  = 3'd2,
    POLL   = 3'd3,
    RD_RES = 3'd4,
    FIN    = 3'd5
  } state_e;

  localparam logic [31:0] OFF_N      = 32'h0000_0000;
  localparam logic [31:0] OFF_GO     = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0008;
  localparam logic [31:0] OFF_RESULT = 32'h0000_000C;

  localparam int ST_DONE = 0;
  localparam int ST_ERR  = 1;

endpackage

// File: rtl/fact_initiator.sv
// Bus master that runs one factorial job on the accelerator: write N, write GO,
// poll STATUS, read RESULT. Poll timeout is built only with FACT_INIT_TIMEOUT_EN.
module fact_initiator
  import fact_initiator_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
  parameter int          POLL_MAX  = 1023,
  parameter int          CNT_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  n,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic [31:0] bus_a,
  output logic        bus_we,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd,
  output logic [2:0]  dbg_state
);

  // Request handshake: start is a one-cycle request honoured only in IDLE
  // (never queued); busy covers the job and done pulses once with result/err.

  if ((CNT_W < 1) || ((64'd1 << CNT_W) <= 64'(POLL_MAX))) begin : g_cnt_w_check
    $error("fact_initiator: CNT_W too narrow for POLL_MAX");
  end

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [31:0] bus_a_q, bus_a_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_wd_q, bus_wd_d;
`ifdef FACT_INIT_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Bus outputs are computed for the state being entered so they appear registered.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    bus_a_d  = bus_a_q;
    bus_we_d = 1'b0;
    bus_wd_d = bus_wd_q;
`ifdef FACT_INIT_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WR_N;
          busy_d   = 1'b1;
          bus_a_d  = BASE_ADDR + OFF_N;
          bus_we_d = 1'b1;
          bus_wd_d = {28'b0, n};
        end
      end
      WR_N: begin
        state_d  = WR_GO;
        bus_a_d  = BASE_ADDR + OFF_GO;
        bus_we_d = 1'b1;
        bus_wd_d = 32'h0000_0001;
      end
      WR_GO: begin
        state_d = POLL;
        bus_a_d = BASE_ADDR + OFF_STATUS;
`ifdef FACT_INIT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      POLL: begin
        if (bus_rd[ST_ERR]) begin
          state_d  = FIN;
          done_d   = 1'b1;
          err_d    = 1'b1;
          result_d = 32'h0;
        end else if (bus_rd[ST_DONE]) begin
          state_d = RD_RES;
          bus_a_d = BASE_ADDR + OFF_RESULT;
        end else begin
`ifdef FACT_INIT_TIMEOUT_EN
          // The POLL_MAX-th empty status read ends the job.
          if (cnt_q == CNT_W'(POLL_MAX - 1)) begin
            state_d  = FIN;
            done_d   = 1'b1;
            err_d    = 1'b1;
            result_d = 32'hFFFF_FFFF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      RD_RES: begin
        state_d  = FIN;
        done_d   = 1'b1;
        err_d    = 1'b0;
        result_d = bus_rd;
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
      err_q    <= 1'b0;
      bus_a_q  <= BASE_ADDR;
      bus_we_q <= 1'b0;
      bus_wd_q <= 32'h0;
`ifdef FACT_INIT_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      bus_a_q  <= bus_a_d;
      bus_we_q <= bus_we_d;
      bus_wd_q <= bus_wd_d;
`ifdef FACT_INIT_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign bus_a     = bus_a_q;
  assign bus_we    = bus_we_q;
  assign bus_wd    = bus_wd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fact_initiator.sv
// Bench for fact_initiator: accelerator register model on the bus, a timing
// model derived from cycle offsets relative to the accepted start, and a per-cycle compare.
module tb_fact_initiator;

  localparam logic [31:0] BASE = 32'h0000_0800;
`ifdef FACT_INIT_TIMEOUT_EN
  localparam int  PMAX  = 8;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  PMAX  = 1023;
  localparam bit  TO_EN = 1'b0;
`endif
  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  n_in = 4'd0;
  logic        busy, done, err, bus_we;
  logic [31:0] result, bus_a, bus_wd, bus_rd;
  logic [2:0]  dbg_state;

  fact_initiator #(.BASE_ADDR(BASE), .POLL_MAX(PMAX), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .busy(busy), .done(done),
    .result(result), .err(err), .bus_a(bus_a), .bus_we(bus_we), .bus_wd(bus_wd),
    .bus_rd(bus_rd), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- accelerator register model ----------------
  int          k_cfg = 0;           // status reads returning 0 before fs_cfg
  logic [31:0] fs_cfg = 32'h1;      // final STATUS value
  logic [31:0] rv_cfg = 32'h0;      // RESULT register contents
  int          poll_seen = 0;

  always_comb begin
    bus_rd = 32'hDEAD_BEEF;
    if (bus_a == BASE + 32'h8)      bus_rd = (poll_seen < k_cfg) ? 32'h0 : fs_cfg;
    else if (bus_a == BASE + 32'hC) bus_rd = rv_cfg;
  end

  always @(posedge clk) begin
    if (bus_we && bus_a == BASE + 32'h4)       poll_seen <= 0;
    else if (!bus_we && bus_a == BASE + 32'h8) poll_seen <= poll_seen + 1;
  end

  // ---------------- behavioural job model ----------------
  bit          act = 1'b0;
  bit          in_rst = 1'b1;
  int          s_cyc = 0, p_cnt = 0, d_rel = 0;
  bit          rd_res = 1'b0, err_path = 1'b0;
  logic [3:0]  cur_n = 4'd0;
  logic [31:0] exp_res = 32'h0, held_res = 32'h0;
  logic        exp_err = 1'b0, held_err = 1'b0;
  int          last_done_rel = -1;
  logic [31:0] exp_q[$];            // expected bus write data in order

  task automatic accept(input logic [3:0] nn, input int k, input logic [31:0] fs,
                        input logic [31:0] rv);
    act = 1'b1; s_cyc = cyc; cur_n = nn; last_done_rel = -1;
    exp_q.push_back({28'b0, nn});
    exp_q.push_back(32'h1);
    if (TO_EN && k >= PMAX) begin
      p_cnt = PMAX; d_rel = 3 + p_cnt; rd_res = 0; err_path = 1;
      exp_res = 32'hFFFF_FFFF; exp_err = 1'b1;
    end else if (fs[1]) begin
      p_cnt = k + 1; d_rel = 3 + p_cnt; rd_res = 0; err_path = 1;
      exp_res = 32'h0; exp_err = 1'b1;
    end else if (fs[0]) begin
      p_cnt = k + 1; d_rel = 4 + p_cnt; rd_res = 1; err_path = 0;
      exp_res = rv; exp_err = 1'b0;
    end else begin
      p_cnt = NEVER; d_rel = NEVER; rd_res = 0; err_path = 0;
      exp_res = 32'h0; exp_err = 1'b0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!in_rst) begin
      int rel;
      bit exp_we;
      rel = act ? (cyc - s_cyc) : -1;
      exp_we = act && (rel == 1 || rel == 2);
      chk("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
      if (bus_we) begin
        if (exp_q.size() == 0) chk("unexpected_write", bus_wd, 32'hFFFF_FFFF);
        else chk("bus_wd", bus_wd, exp_q.pop_front());
      end
      if (act && rel == 1) chk("addr_n", bus_a, BASE);
      if (act && rel == 2) chk("addr_go", bus_a, BASE + 32'h4);
      if (act && rel >= 3 && rel < 3 + p_cnt) chk("addr_status", bus_a, BASE + 32'h8);
      if (act && rd_res && rel == 3 + p_cnt) chk("addr_result", bus_a, BASE + 32'hC);
      if (act && err_path && rel >= 1 && rel <= d_rel)
        chk("result_not_addressed", {31'b0, bus_a == BASE + 32'hC}, 32'h0);
      chk("done", {31'b0, done}, {31'b0, act && rel == d_rel});
      chk("busy", {31'b0, busy}, {31'b0, act && rel >= 1 && rel <= d_rel});
      if (act && rel == d_rel) begin
        held_res = exp_res;
        held_err = exp_err;
      end
      if (done) last_done_rel = rel;
      chk("result", result, held_res);
      chk("err", {31'b0, err}, {31'b0, held_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},   {31'b0, busy},   32'h0);
    chk({tag, "_done"},   {31'b0, done},   32'h0);
    chk({tag, "_result"}, result,          32'h0);
    chk({tag, "_err"},    {31'b0, err},    32'h0);
    chk({tag, "_bus_we"}, {31'b0, bus_we}, 32'h0);
    chk({tag, "_bus_wd"}, bus_wd,          32'h0);
    chk({tag, "_bus_a"},  bus_a,           BASE);
  endtask

  task automatic assert_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b0; in_rst = 1'b1; start = 1'b0;
    act = 1'b0; held_res = 32'h0; held_err = 1'b0; exp_q.delete();
    #1 check_reset_values(tag);
    repeat (2) @(posedge clk);
    #1 check_reset_values({tag, "_held"});
    rst = 1'b1; in_rst = 1'b0;
  endtask

  task automatic launch(input logic [3:0] nn, input int k, input logic [31:0] fs,
                        input logic [31:0] rv);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (act && (cyc - s_cyc) <= d_rel && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    k_cfg = k; fs_cfg = fs; rv_cfg = rv;
    n_in = nn; start = 1'b1;
    accept(nn, k, fs, rv);
  endtask

  task automatic run_txn(input logic [3:0] nn, input int k, input logic [31:0] fs,
                         input logic [31:0] rv, input bit pulse_mid, input bit pulse_fin);
    int rel;
    launch(nn, k, fs, rv);
    rel = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rel = cyc - s_cyc;
      start = (pulse_mid && rel == 4) || (pulse_fin && rel == d_rel);
      n_in = 4'($urandom_range(0, 15));
      if (rel > d_rel) break;
    end
    start = 1'b0;
    if (rel <= d_rel) chk("job_budget_expired", 32'(rel), 32'(d_rel + 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_values("por");
    rst = 1'b1; in_rst = 1'b0;
    repeat (2) @(posedge clk);

    // n=5: two empty polls, then done; RESULT = 5!
    run_txn(4'd5, 2, 32'h1, 32'h0000_0078, 0, 0);
    chk("n5_result", result, 32'h0000_0078);
    chk("n5_latency", 32'(last_done_rel), 32'd7);

    // n=12: done on first poll, minimum latency
    run_txn(4'd12, 0, 32'h1, 32'h1C8C_FC00, 0, 0);
    chk("n12_result", result, 32'h1C8C_FC00);
    chk("n12_err", {31'b0, err}, 32'h0);
    chk("n12_latency", 32'(last_done_rel), 32'd5);

    // n=13: STATUS=3, error wins over done
    run_txn(4'd13, 1, 32'h3, 32'h1234_5678, 0, 0);
    chk("n13_result", result, 32'h0);
    chk("n13_err", {31'b0, err}, 32'h1);
    chk("n13_latency", 32'(last_done_rel), 32'd5);

    // start during POLL and during FIN must be ignored
    run_txn(4'd7, 3, 32'h1, 32'h0000_13B0, 1, 1);
    repeat (10) @(posedge clk);
    chk("n7_result", result, 32'h0000_13B0);

    // reset in the middle of POLL, then a fresh job
    launch(4'd9, 10, 32'h1, 32'h0005_8980);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    assert_reset("midpoll_rst");
    run_txn(4'd3, 1, 32'h1, 32'h0000_0006, 0, 0);
    chk("n3_result", result, 32'h0000_0006);

    // randomized jobs
    for (int t = 0; t < 25; t++) begin
      logic [31:0] fs;
      case ($urandom_range(0, 3))
        0:       fs = 32'h3;
        1:       fs = 32'h2;
        default: fs = 32'h1;
      endcase
      run_txn(4'($urandom_range(0, 15)), int'($urandom_range(0, 5)), fs, $urandom,
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

`ifdef FACT_INIT_TIMEOUT_EN
    run_txn(4'd6, 100000, 32'h0, 32'h0, 0, 0);
    chk("timeout_result", result, 32'hFFFF_FFFF);
    chk("timeout_err", {31'b0, err}, 32'h1);
    chk("timeout_latency", 32'(last_done_rel), 32'd11);
`else
    // no timeout: status stuck at 0 keeps the job busy
    launch(4'd6, 100000, 32'h0, 32'h0);
    @(posedge clk); #1 start = 1'b0;
    repeat (200) @(posedge clk);
    #1 chk("stuck_busy", {31'b0, busy}, 32'h1);
    assert_reset("stuck_rst");
`endif

    repeat (5) @(posedge clk);
    chk("writes_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
